// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and framing constants.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
    localparam int DATA_BITS = 8;
    localparam int DEFAULT_DIV = 434;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous pad inputs.
module sync_2ff #(
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk) begin
        if (rst) {q, meta} <= {2{INIT}};
        else     {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first receiver with mid-bit sampling and a valid/ready holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int HALF = DIV / 2;
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(DATA_BITS);

    state_t state, next;
    logic rx_s, tick, sample, deliver, ferr;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [DATA_BITS-1:0] shreg;

    sync_2ff #(.INIT(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:      next = rx_s ? IDLE : START;
            START:     next = tick ? (rx_s ? IDLE : DATA) : START;
            DATA:      next = (tick && idx == IW'(DATA_BITS - 1)) ? STOP : DATA;
            STOP:      next = tick ? (rx_s ? IDLE : WAIT_IDLE) : STOP;
            WAIT_IDLE: next = rx_s ? IDLE : WAIT_IDLE;
            default:   next = IDLE;
        endcase
        if (!ena) next = IDLE;
    end

    always_comb begin
        tick    = cnt == '0;
        sample  = ena && state == DATA && tick;
        deliver = ena && state == STOP && tick && rx_s;
        ferr    = ena && state == STOP && tick && !rx_s;
        busy    = state != IDLE;
    end

    // IDLE keeps the counter preloaded so START measures exactly half a bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            cnt       <= state == IDLE ? CW'(HALF - 1) : tick ? CW'(DIV - 1) : cnt - 1'b1;
            idx       <= state == START ? '0 : sample ? idx + 1'b1 : idx;
            shreg     <= sample ? {rx_s, shreg[DATA_BITS-1:1]} : shreg;
            frame_err <= ferr;
            overrun   <= deliver && valid && !ready;
            if (deliver && (!valid || ready)) begin
                data  <= shreg;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule
